ex_stage: RTL and testbench

//  Execute stage; consumes the ex_*_i bundle registered by the ID/EX pipeline register.
//  - Computes logic, shift, arithmetic, move and link results plus HI/LO updates for MULT, MULTU, DIV and DIVU.
//  - Hosts a multi-cycle radix-2 divider FSM; raises stallreq_o to the stall controller while a division is in flight.
//  - Outputs feed the EX/MEM register and the ID-stage forwarding path.

---
 rtl/ex_stage_pkg.sv | 30 +++
 rtl/ex_div.sv | 65 ++++++
 rtl/ex_stage.sv | 90 +++++++++
 tb/tb_ex_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared execute-stage types (project_types) and ALU decode encodings (decode_table).
package project_types;
    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE = 1'b0;
    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);
    typedef struct packed {
        logic       we;
        logic [4:0] addr;
    } reg_info_t;
    typedef struct packed {
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_fwd_t;
    typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_t;
endpackage

package decode_table;
    typedef enum logic [4:0] {
        OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO,
        OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
    } alu_op_t;
    typedef enum logic [2:0] {SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_MOVE, SEL_LINK} alu_sel_t;
    typedef struct packed {
        alu_op_t  op;
        alu_sel_t sel;
    } alu_t;
endpackage

// File: rtl/ex_div.sv
// ex_div: radix-2 restoring divider, one quotient bit per cycle, with signed fix-up.
// Only compiled when EX_DIV_EN is defined, matching its instantiation in ex_stage.
`ifdef EX_DIV_EN
module ex_div
    import project_types::*;
(
    input  logic          clk,
    input  reset_status_t rst,
    input  logic          start,
    input  logic          signed_i,
    input  logic [31:0]   a,
    input  logic [31:0]   b,
    output logic [31:0]   quotient,
    output logic [31:0]   remainder,
    output logic          result_valid,
    output logic          busy
);
    div_state_t state, state_n;
    logic [DIV_CNT_W-1:0] count;
    logic [31:0] rem, quo, dvs;
    logic neg_q, neg_r, fits;
    logic [32:0] trial;
    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {rem, quo[31]};
    assign fits  = trial >= {1'b0, dvs};
    always_comb begin
        state_n = state;
        case (state)
            DIV_FREE:   state_n = start ? (b == '0 ? DIV_BYZERO : DIV_ON) : DIV_FREE;
            DIV_ON:     state_n = count == DIV_CNT_W'(DIV_CYCLES - 1) ? DIV_END : DIV_ON;
            DIV_BYZERO: state_n = DIV_END;
            default:    state_n = DIV_FREE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= DIV_FREE;
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DIV_FREE && start) begin
                count <= '0;
                rem   <= '0;
                quo   <= b == '0 ? '0 : (signed_i && a[31] ? -a : a);
                dvs   <= signed_i && b[31] ? -b : b;
                neg_q <= signed_i && (a[31] ^ b[31]);
                neg_r <= signed_i && a[31];
            end else if (state == DIV_ON) begin
                count <= count + DIV_CNT_W'(1);
                rem   <= fits ? 32'(trial - {1'b0, dvs}) : trial[31:0];
                quo   <= {quo[30:0], fits};
            end
        end
    end
    assign quotient     = neg_q ? -quo : quo;
    assign remainder    = neg_r ? -rem : rem;
    assign result_valid = state == DIV_END;
    assign busy         = (state == DIV_FREE && start) || state == DIV_ON || state == DIV_BYZERO;
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, shifts, multiply, HI/LO moves, link and DIV/DIVU.
// Define EX_DIV_EN for the multi-cycle divider; otherwise DIV/DIVU write zero HI/LO in one cycle.
module ex_stage
    import project_types::*;
    import decode_table::*;
(
    input  logic          clk,
    input  reset_status_t rst,
    input  alu_t          ex_alu_i,
    input  logic [31:0]   ex_oprd1_i,
    input  logic [31:0]   ex_oprd2_i,
    input  reg_info_t     ex_wreg_i,
    input  logic [31:0]   ex_link_addr_i,
    input  logic [31:0]   hi_i,
    input  logic [31:0]   lo_i,
    input  hilo_fwd_t     mem_hilo_i,
    input  hilo_fwd_t     wb_hilo_i,
    output reg_info_t     ex_wreg_o,
    output logic [31:0]   ex_wdata_o,
    output hilo_fwd_t     ex_hilo_o,
    output logic          stallreq_o
);
    logic [31:0] hi_fwd, lo_fwd, op_res, div_q, div_r;
    logic [63:0] prod_s, prod_u;
    logic [64:0] hilo_res;
    logic live, div_op, div_valid, div_busy;
    assign live   = rst != RST_ENABLE;
    assign hi_fwd = mem_hilo_i.we ? mem_hilo_i.hi : wb_hilo_i.we ? wb_hilo_i.hi : hi_i;
    assign lo_fwd = mem_hilo_i.we ? mem_hilo_i.lo : wb_hilo_i.we ? wb_hilo_i.lo : lo_i;
    assign div_op = ex_alu_i.op inside {OP_DIV, OP_DIVU};
    assign prod_s = 64'($signed(ex_oprd1_i)) * 64'($signed(ex_oprd2_i));
    assign prod_u = 64'(ex_oprd1_i) * 64'(ex_oprd2_i);
    always_comb begin
        case (ex_alu_i.op)
            OP_AND:          op_res = ex_oprd1_i & ex_oprd2_i;
            OP_OR:           op_res = ex_oprd1_i | ex_oprd2_i;
            OP_XOR:          op_res = ex_oprd1_i ^ ex_oprd2_i;
            OP_NOR:          op_res = ~(ex_oprd1_i | ex_oprd2_i);
            OP_SLL:          op_res = ex_oprd2_i << ex_oprd1_i[4:0];
            OP_SRL:          op_res = ex_oprd2_i >> ex_oprd1_i[4:0];
            OP_SRA:          op_res = $signed(ex_oprd2_i) >>> ex_oprd1_i[4:0];
            OP_ADD, OP_ADDU: op_res = ex_oprd1_i + ex_oprd2_i;
            OP_SUB, OP_SUBU: op_res = ex_oprd1_i - ex_oprd2_i;
            OP_SLT:          op_res = {31'b0, $signed(ex_oprd1_i) < $signed(ex_oprd2_i)};
            OP_SLTU:         op_res = {31'b0, ex_oprd1_i < ex_oprd2_i};
            OP_MFHI:         op_res = hi_fwd;
            OP_MFLO:         op_res = lo_fwd;
            default:         op_res = '0;
        endcase
    end
    always_comb begin
        case (ex_alu_i.op)
            OP_MULT:  hilo_res = {1'b1, prod_s};
            OP_MULTU: hilo_res = {1'b1, prod_u};
            OP_MTHI:  hilo_res = {1'b1, ex_oprd1_i, lo_fwd};
            OP_MTLO:  hilo_res = {1'b1, hi_fwd, ex_oprd1_i};
            default:  hilo_res = '0;
        endcase
    end
`ifdef EX_DIV_EN
    ex_div u_div (
        .clk          (clk),
        .rst          (rst),
        .start        (div_op),
        .signed_i     (ex_alu_i.op == OP_DIV),
        .a            (ex_oprd1_i),
        .b            (ex_oprd2_i),
        .quotient     (div_q),
        .remainder    (div_r),
        .result_valid (div_valid),
        .busy         (div_busy)
    );
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign div_q      = '0;
    assign div_r      = '0;
    assign div_valid  = div_op;
    assign div_busy   = 1'b0;
`endif
    // a division in flight suppresses both register-file and HI/LO writes
    always_comb begin
        ex_wreg_o.we   = live && ex_wreg_i.we && !div_busy;
        ex_wreg_o.addr = live ? ex_wreg_i.addr : '0;
        ex_wdata_o     = !live ? '0 : ex_alu_i.sel == SEL_LINK ? ex_link_addr_i :
                         ex_alu_i.sel == SEL_NOP ? '0 : op_res;
        ex_hilo_o      = !live || div_busy ? '0 : div_valid ? {1'b1, div_r, div_q} : hilo_res;
        stallreq_o     = live && div_busy;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized ex_stage bench against an arithmetic reference model, plus directed literals.
module tb_ex_stage;
    import project_types::*;
    import decode_table::*;

    logic          clk;
    reset_status_t rst;
    alu_t          ex_alu_i;
    logic [31:0]   ex_oprd1_i, ex_oprd2_i, ex_link_addr_i, hi_i, lo_i;
    reg_info_t     ex_wreg_i, ex_wreg_o;
    hilo_fwd_t     mem_hilo_i, wb_hilo_i, ex_hilo_o;
    logic [31:0]   ex_wdata_o;
    logic          stallreq_o;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_alu_i       (ex_alu_i),
        .ex_oprd1_i     (ex_oprd1_i),
        .ex_oprd2_i     (ex_oprd2_i),
        .ex_wreg_i      (ex_wreg_i),
        .ex_link_addr_i (ex_link_addr_i),
        .hi_i           (hi_i),
        .lo_i           (lo_i),
        .mem_hilo_i     (mem_hilo_i),
        .wb_hilo_i      (wb_hilo_i),
        .ex_wreg_o      (ex_wreg_o),
        .ex_wdata_o     (ex_wdata_o),
        .ex_hilo_o      (ex_hilo_o),
        .stallreq_o     (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic alu_sel_t sel_of(input alu_op_t op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR:                     return SEL_LOGIC;
            OP_SLL, OP_SRL, OP_SRA:                            return SEL_SHIFT;
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU: return SEL_ARITH;
            OP_MFHI, OP_MFLO:                                  return SEL_MOVE;
            default:                                           return SEL_NOP;
        endcase
    endfunction

    function automatic logic [31:0] gpr_of(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
        int sa;
        sa = int'(a[4:0]);
        case (op)
            OP_AND:          return a & b;
            OP_OR:           return a | b;
            OP_XOR:          return a ^ b;
            OP_NOR:          return ~(a | b);
            OP_SLL:          return b << sa;
            OP_SRL:          return b >> sa;
            OP_SRA:          return int'(b) >>> sa;
            OP_ADD, OP_ADDU: return 32'(longint'(a) + longint'(b));
            OP_SUB, OP_SUBU: return 32'(longint'(a) - longint'(b));
            OP_SLT:          return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU:         return (a < b) ? 32'd1 : 32'd0;
            OP_MFHI:         return hi;
            OP_MFLO:         return lo;
            default:         return 32'd0;
        endcase
    endfunction

    function automatic logic [64:0] hilo_of(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
        longint sp;
        longint unsigned up;
        case (op)
            OP_MULT: begin
                sp = longint'(int'(a)) * longint'(int'(b));
                return {1'b1, 64'(sp)};
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                return {1'b1, up};
            end
            OP_MTHI: return {1'b1, a, lo};
            OP_MTLO: return {1'b1, hi, a};
            default: return 65'd0;
        endcase
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] div_of(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'(int'(a));
            y = longint'(int'(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        q = x / y;
        r = x % y;
        return {32'(r), 32'(q)};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // reference model: division is a countdown of remaining busy cycles plus a pending result
    bit          m_busy = 0;
    bit          m_end = 0;
    int          m_left = 0;
    logic [63:0] m_res = '0;

    always @(negedge clk) begin
        logic [31:0] hi_e, lo_e, e_wdata;
        logic [64:0] e_hilo;
        reg_info_t   e_wreg;
        logic        e_stall;
        bit          div_in;
        hi_e    = mem_hilo_i.we ? mem_hilo_i.hi : wb_hilo_i.we ? wb_hilo_i.hi : hi_i;
        lo_e    = mem_hilo_i.we ? mem_hilo_i.lo : wb_hilo_i.we ? wb_hilo_i.lo : lo_i;
        div_in  = ex_alu_i.op inside {OP_DIV, OP_DIVU};
        e_wdata = ex_alu_i.sel == SEL_LINK ? ex_link_addr_i : gpr_of(ex_alu_i.op, ex_oprd1_i, ex_oprd2_i, hi_e, lo_e);
        e_hilo  = hilo_of(ex_alu_i.op, ex_oprd1_i, ex_oprd2_i, hi_e, lo_e);
        e_wreg  = ex_wreg_i;
        e_stall = 1'b0;
`ifdef EX_DIV_EN
        if (m_end) e_hilo = {1'b1, m_res};
        else if (m_busy || div_in) begin
            e_stall   = 1'b1;
            e_hilo    = '0;
            e_wreg.we = 1'b0;
        end
`else
        if (div_in) e_hilo = {1'b1, 64'd0};
`endif
        if (rst == RST_ENABLE) begin
            e_wdata = '0;
            e_hilo  = '0;
            e_wreg  = '0;
            e_stall = 1'b0;
        end
        chk("stallreq", 65'(stallreq_o), 65'(e_stall));
        chk("wdata", 65'(ex_wdata_o), 65'(e_wdata));
        chk("wreg", 65'(ex_wreg_o), 65'(e_wreg));
        chk("hilo_we", 65'(ex_hilo_o.we), 65'(e_hilo[64]));
        if (e_hilo[64]) chk("hilo", ex_hilo_o, e_hilo);
`ifdef EX_DIV_EN
        if (rst == RST_ENABLE) begin
            m_busy = 0;
            m_end  = 0;
        end else if (m_end) m_end = 0;
        else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_end  = 1;
            end
        end else if (div_in) begin
            m_busy = 1;
            m_left = ex_oprd2_i == 32'd0 ? 1 : DIV_CYCLES;
            m_res  = div_of(ex_alu_i.op == OP_DIV, ex_oprd1_i, ex_oprd2_i);
        end
`endif
    end

    task automatic apply(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        ex_alu_i.op  = op;
        ex_alu_i.sel = sel_of(op);
        ex_oprd1_i   = a;
        ex_oprd2_i   = b;
    endtask

    task automatic run_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_n, input logic [63:0] exp_hl, input string tag);
        int n;
        n = 0;
        apply(op, a, b);
        @(negedge clk);
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " stall cycles"}, 65'(n), 65'(exp_n));
        chk({tag, " result"}, ex_hilo_o, {1'b1, exp_hl});
    endtask

    initial begin
        rst            = 1'b0;
        ex_alu_i.op    = OP_ADDU;
        ex_alu_i.sel   = SEL_ARITH;
        ex_oprd1_i     = 32'h1234;
        ex_oprd2_i     = 32'h5678;
        ex_wreg_i      = '{we: 1'b1, addr: 5'd3};
        ex_link_addr_i = 32'h0040_0010;
        hi_i           = 32'hAAAA_0000;
        lo_i           = 32'h0000_BBBB;
        mem_hilo_i     = '{we: 1'b1, hi: 32'h1, lo: 32'h2};
        wb_hilo_i      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset wdata", 65'(ex_wdata_o), 65'd0);
        chk("reset wreg", 65'(ex_wreg_o), 65'd0);
        chk("reset hilo", ex_hilo_o, 65'd0);
        chk("reset stall", 65'(stallreq_o), 65'd0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        mem_hilo_i = '0;
        apply(OP_ADDU, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("addu wrap", 65'(ex_wdata_o), 65'd0);
        chk("addu wreg", 65'(ex_wreg_o), 65'({1'b1, 5'd3}));
        apply(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("slt", 65'(ex_wdata_o), 65'd1);
        apply(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("sltu", 65'(ex_wdata_o), 65'd0);
        apply(OP_SRA, 32'd4, 32'h8000_0000);
        @(negedge clk);
        chk("sra", 65'(ex_wdata_o), 65'(32'hF800_0000));
        apply(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        chk("mult", ex_hilo_o, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        mem_hilo_i = '{we: 1'b1, hi: 32'h11, lo: 32'h0};
        wb_hilo_i  = '{we: 1'b1, hi: 32'h22, lo: 32'h0};
        apply(OP_MFHI, 32'd0, 32'd0);
        @(negedge clk);
        chk("mfhi fwd", 65'(ex_wdata_o), 65'(32'h11));
        mem_hilo_i = '0;
        wb_hilo_i  = '0;
        @(posedge clk);
        #1;
        ex_alu_i.op  = OP_NOP;
        ex_alu_i.sel = SEL_LINK;
        @(negedge clk);
        chk("link", 65'(ex_wdata_o), 65'(32'h0040_0010));
`ifdef EX_DIV_EN
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div -7/2");
        run_div(OP_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "divu 100/7");
        run_div(OP_DIVU, 32'h1234, 32'd0, 2, 64'd0, "divu by zero");
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, "div overflow");
        apply(OP_DIV, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        rst         = 1'b0;
        ex_alu_i.op = OP_NOP;
        @(negedge clk);
        chk("stall in reset", 65'(stallreq_o), 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("stall after reset", 65'(stallreq_o), 65'd0);
        run_div(OP_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14}, "div after reset");
`else
        apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        chk("nodiv hilo", ex_hilo_o, {1'b1, 64'd0});
        repeat (5) begin
            chk("nodiv stall", 65'(stallreq_o), 65'd0);
            @(negedge clk);
        end
`endif
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst          = reset_status_t'($urandom_range(0, 199) != 0);
            ex_alu_i.op  = alu_op_t'($urandom_range(0, 21));
            if (ex_alu_i.op inside {OP_DIV, OP_DIVU} && $urandom_range(0, 2) != 0) ex_alu_i.op = OP_ADDU;
            ex_alu_i.sel = sel_of(ex_alu_i.op);
            if ($urandom_range(0, 15) == 0) begin
                ex_alu_i.op  = OP_NOP;
                ex_alu_i.sel = SEL_LINK;
            end
            ex_oprd1_i     = rnd32();
            ex_oprd2_i     = rnd32();
            ex_link_addr_i = $urandom;
            hi_i           = $urandom;
            lo_i           = $urandom;
            mem_hilo_i     = {1'($urandom_range(0, 1)), $urandom, $urandom};
            wb_hilo_i      = {1'($urandom_range(0, 1)), $urandom, $urandom};
            ex_wreg_i      = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 31))};
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
